// File: rtl/fifo_pkg.sv
// Shared types and sizing helpers for the FIFO stream reader slice.
package fifo_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} rd_state_t;

  localparam int SKID_DEPTH = 2;

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/skid_buf2.sv
// Two-entry {data, last} buffer that absorbs the FIFO read latency.
module skid_buf2
  import fifo_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             push_last,
  input  logic             pop,
  output logic [1:0]       occ,
  output logic [WIDTH-1:0] head_data,
  output logic             head_last
);

  logic [WIDTH-1:0] data_mem [SKID_DEPTH];
  logic             last_mem [SKID_DEPTH];
  logic             wr_ptr;
  logic             rd_ptr;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      occ    <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

  // Storage carries no reset; the head mux forces zeros while empty.
  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[wr_ptr] <= push_data;
      last_mem[wr_ptr] <= push_last;
    end
  end

  assign head_data = (occ != 2'd0) ? data_mem[rd_ptr] : '0;
  assign head_last = (occ != 2'd0) ? last_mem[rd_ptr] : 1'b0;

  a_occ_range: assert property (@(posedge clk) disable iff (!rstn)
    occ <= 2'(SKID_DEPTH));
  a_no_overflow: assert property (@(posedge clk) disable iff (!rstn)
    !(push && !pop && occ == 2'(SKID_DEPTH)));

endmodule

// File: rtl/fifo_stream_reader.sv
// Pops words from a synchronous FIFO and streams them out with a per-burst last flag.
module fifo_stream_reader
  import fifo_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int BURST_LEN = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic             fifo_empty,
  output logic             fifo_rd_en,
  input  logic [WIDTH-1:0] fifo_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic             m_last,
  output logic             busy
);

  localparam int CNT_W = cnt_w(BURST_LEN);

  rd_state_t        state;
  rd_state_t        state_nxt;
  logic             inflight;
  logic [CNT_W-1:0] burst_cnt;
  logic [1:0]       occ;
  logic             pop;
  logic             cap_last;
  logic [2:0]       pending;

  assign m_valid = (occ != 2'd0);
  assign pop     = m_valid & m_ready;

  // Slots claimed after this cycle; a new read is only safe if one stays free.
  assign pending    = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
  assign fifo_rd_en = (state == RUN) & ~fifo_empty & (pending < 3'd2);

  assign cap_last = (burst_cnt == CNT_W'(BURST_LEN - 1));
  assign busy     = (state != IDLE) | (occ != 2'd0) | inflight;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (en) state_nxt = RUN;
      RUN:     if (!en) state_nxt = DRAIN;
      DRAIN: begin
        if (en)                                   state_nxt = RUN;
        else if (!inflight && (occ == 2'd0))      state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      inflight  <= 1'b0;
      burst_cnt <= '0;
    end else begin
      state    <= state_nxt;
      inflight <= fifo_rd_en;
      // Burst position survives IDLE/DRAIN so partial bursts resume.
      if (inflight) burst_cnt <= cap_last ? '0 : burst_cnt + CNT_W'(1);
    end
  end

  skid_buf2 #(.WIDTH(WIDTH)) u_skid (
    .clk       (clk),
    .rstn      (rstn),
    .push      (inflight),
    .push_data (fifo_data),
    .push_last (cap_last),
    .pop       (pop),
    .occ       (occ),
    .head_data (m_data),
    .head_last (m_last)
  );

endmodule
